// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: state encoding, byte width and index-width helper shared by the UART TX arbiter
package uart_arb_pkg;
    localparam int UART_DW = 8;
    typedef enum logic [2:0] {IDLE, ISSUE, START, SETTLE, WAIT, GAP} arb_state_t;
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin encoder (req, last in; any, idx out), nearest requester above last wins
module rr_pick import uart_arb_pkg::*; #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [clog2w(N)-1:0] last,
    output logic                 any,
    output logic [clog2w(N)-1:0] idx
);
    localparam int W = clog2w(N);
    logic [W-1:0] cand;
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int i = N; i >= 1; i--) begin
            cand = W'((int'(last) + i) % N);
            if (req[cand]) idx = cand;
        end
    end
    assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART TX core (req_* in, tx_* out, grant/stall status out)
module uart_tx_arbiter import uart_arb_pkg::*; #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 0,
    parameter int STALL_MAX  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [UART_DW*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_start,
    output logic [UART_DW-1:0]      tx_data,
    input  logic                    tx_busy,
    output logic [clog2w(NREQ)-1:0] grant_id,
    output logic                    grant_active,
    output logic                    stall_abort
);
    localparam int GW  = clog2w(NREQ);
    localparam int GCW = clog2w(GAP_CYCLES);
    localparam int SCW = clog2w(STALL_MAX + 1);
    arb_state_t                   state;
    logic [NREQ-1:0][UART_DW-1:0] req_bytes;
    logic [GW-1:0]                last_grant;
    logic [GW-1:0]                pick_idx;
    logic [GCW-1:0]               gap_cnt;
    logic [SCW-1:0]               stall_cnt;
    logic                         pick_any;
    logic                         last_q;
    logic                         grant_valid;
    logic                         accept;
    logic                         stall_hit;
    logic                         frame_done;
    assign req_bytes   = req_data;
    assign grant_valid = req_valid[grant_id];
    assign accept      = (state == ISSUE) && grant_valid && !tx_busy;
    assign stall_hit   = (state == ISSUE) && !grant_valid && (STALL_MAX != 0) && (int'(stall_cnt) + 1 >= STALL_MAX);
    assign frame_done  = (GAP_CYCLES == 0) ? ((state == WAIT) && !tx_busy)
                                           : ((state == GAP) && (int'(gap_cnt) == GAP_CYCLES - 1));
    assign req_ready   = accept ? (NREQ'(1) << grant_id) : '0;
    rr_pick #(.N(NREQ)) u_pick (
        .req  (req_valid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            stall_abort  <= 1'b0;
            last_grant   <= GW'(NREQ - 1);
            last_q       <= 1'b0;
            gap_cnt      <= '0;
            stall_cnt    <= '0;
        end else begin
            tx_start    <= accept;
            stall_abort <= stall_hit;
            case (state)
                IDLE: if (pick_any) begin
                    grant_id     <= pick_idx;
                    grant_active <= 1'b1;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    if (grant_valid || stall_hit) stall_cnt <= '0;
                    else if (int'(stall_cnt) < STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
                    if (accept) begin
                        tx_data <= req_bytes[grant_id];
                        last_q  <= req_last[grant_id];
                        state   <= START;
                    end else if (stall_hit) begin
                        grant_active <= 1'b0;
                        last_grant   <= grant_id;
                        state        <= IDLE;
                    end
                end
                START:  state <= SETTLE;
                SETTLE: state <= WAIT;
                WAIT: begin
                    gap_cnt <= '0;
                    if (!tx_busy && GAP_CYCLES > 0) state <= GAP;
                end
                GAP:     gap_cnt <= gap_cnt + 1'b1;
                default: state <= IDLE;
            endcase
            if (frame_done) begin
                state        <= last_q ? IDLE : ISSUE;
                grant_active <= !last_q;
                last_grant   <= last_q ? grant_id : last_grant;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with behavioural requesters and TX core
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int FRAME = 10;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid, req_last, req_ready;
    logic [8*NREQ-1:0] req_data;
    logic              tx_start, tx_busy, grant_active, stall_abort;
    logic [7:0]        tx_data;
    logic [1:0]        grant_id;
    logic [NREQ-1:0]   g_valid, g_last, g_ready;
    logic [8*NREQ-1:0] g_data;
    logic              g_start, g_busy, g_active, g_abort;
    logic [7:0]        g_txd;
    logic [1:0]        g_id;
    int                busy_cnt = 0, g_busy_cnt = 0, cyc = 0;
    int                n_checks = 0, n_fail = 0;
    logic [8:0]        src_q [NREQ][$];
    logic [9:0]        exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(0), .STALL_MAX(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .grant_active(grant_active), .stall_abort(stall_abort)
    );
    uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(5), .STALL_MAX(8)) dut_g (
        .clk(clk), .rst(rst), .req_valid(g_valid), .req_data(g_data), .req_last(g_last),
        .req_ready(g_ready), .tx_start(g_start), .tx_data(g_txd), .tx_busy(g_busy),
        .grant_id(g_id), .grant_active(g_active), .stall_abort(g_abort)
    );

    always @(posedge clk or posedge rst)
        if (rst) busy_cnt <= 0;
        else busy_cnt <= tx_start ? FRAME : (busy_cnt > 0 ? busy_cnt - 1 : 0);
    always @(posedge clk or posedge rst)
        if (rst) g_busy_cnt <= 0;
        else g_busy_cnt <= g_start ? FRAME : (g_busy_cnt > 0 ? g_busy_cnt - 1 : 0);
    assign tx_busy = busy_cnt != 0;
    assign g_busy  = g_busy_cnt != 0;

    initial begin
        logic [NREQ-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) src_q[i].delete(0);
                req_valid[i]       = src_q[i].size() > 0;
                req_data[8*i +: 8] = src_q[i].size() > 0 ? src_q[i][0][7:0] : 8'h00;
                req_last[i]        = src_q[i].size() > 0 && src_q[i][0][8];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && tx_start) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_order: got id=%0d data=%h, expected no transmission", grant_id, tx_data);
            end else begin
                if ({grant_id, tx_data} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL tx_order: got id=%0d data=%h, expected id=%0d data=%h",
                             grant_id, tx_data, exp_q[0][9:8], exp_q[0][7:0]);
                end
                exp_q.delete(0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time %0t, expected finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_fall(input bit g, output bit ok, output int at);
        bit seen;
        seen = 0;
        ok   = 0;
        at   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (g ? g_busy : tx_busy) seen = 1;
            else if (seen) begin
                ok = 1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !grant_active && !tx_busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tx_start, grant_active, stall_abort} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 000", {tx_start, grant_active, stall_abort});
        end
        n_checks++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_data: got %h, expected 00", tx_data);
        end
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b, expected 0000", req_ready);
        end
        n_checks++;
        if (grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_grant_id: got %0d, expected 0", grant_id);
        end
        rst = 0;
    endtask

    task automatic test_single;
        bit ok;
        int f;
        @(negedge clk);
        src_q[2].push_back({1'b1, 8'h55});
        exp_q.push_back({2'd2, 8'h55});
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0000 || grant_active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got ready=%b active=%b, expected 0000/0", req_ready, grant_active);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_ready: got ready=%b id=%0d, expected 0100/2", req_ready, grant_id);
        end
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55) begin
            n_fail++;
            $display("FAIL single_start: got start=%b data=%h, expected 1/55", tx_start, tx_data);
        end
        wait_fall(0, ok, f);
        n_checks++;
        if (!ok || grant_active !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_fall: got seen=%b active=%b, expected 1/1", ok, grant_active);
        end
        @(negedge clk);
        n_checks++;
        if (grant_active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got active=%b, expected 0", grant_active);
        end
    endtask

    task automatic test_rr;
        bit ok;
        do_reset;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                src_q[i].push_back({1'b1, 8'(8'hA0 + i)});
                exp_q.push_back({2'(i), 8'(8'hA0 + i)});
            end
            wait_drain(ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rr_drain round %0d: got %0d bytes pending, expected 0", r, exp_q.size());
            end
        end
    endtask

    task automatic test_packet;
        bit ok;
        int f;
        @(negedge clk);
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b0, 8'h22});
        src_q[1].push_back({1'b1, 8'h33});
        exp_q.push_back({2'd1, 8'h11});
        exp_q.push_back({2'd1, 8'h22});
        exp_q.push_back({2'd1, 8'h33});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant_active) break;
        end
        n_checks++;
        if (grant_active !== 1'b1 || grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL packet_lock: got active=%b id=%0d, expected 1/1", grant_active, grant_id);
        end
        src_q[0].push_back({1'b1, 8'h0F});
        exp_q.push_back({2'd0, 8'h0F});
        wait_fall(0, ok, f);
        @(negedge clk);
        n_checks++;
        if (!ok || req_ready !== 4'b0010 || grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL packet_next_ready: got fall=%b ready=%b id=%0d, expected 1/0010/1", ok, req_ready, grant_id);
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL packet_drain: got %0d bytes pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_gap;
        bit ok;
        int f, r;
        @(negedge clk);
        g_valid = 4'b0001;
        g_data  = 32'h01;
        g_last  = 4'b0000;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (g_ready[0]) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL gap_first_ready: got no ready, expected ready within 20 cycles");
        end
        @(posedge clk);
        #1;
        g_data = 32'h02;
        g_last = 4'b0001;
        wait_fall(1, ok, f);
        r = f;
        for (int i = 0; i < 40 && ok; i++) begin
            @(negedge clk);
            if (g_ready !== 4'b0000) begin
                r = cyc;
                break;
            end
        end
        n_checks++;
        if (r - f - 1 != 5) begin
            n_fail++;
            $display("FAIL gap_cycles: got %0d idle cycles, expected 5", r - f - 1);
        end
        @(negedge clk);
        n_checks++;
        if (g_start !== 1'b1 || g_txd !== 8'h02) begin
            n_fail++;
            $display("FAIL gap_second_start: got start=%b data=%h, expected 1/02", g_start, g_txd);
        end
        @(posedge clk);
        #1;
        g_valid = '0;
        g_last  = '0;
        wait_fall(1, ok, f);
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok || g_active !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_hold_lock: got fall=%b active=%b, expected 1/1", ok, g_active);
        end
        @(negedge clk);
        n_checks++;
        if (g_active !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_release: got active=%b, expected 0", g_active);
        end
    endtask

    task automatic test_stall;
        bit ok;
        int f;
        @(negedge clk);
        src_q[1].push_back({1'b0, 8'h44});
        src_q[2].push_back({1'b1, 8'h66});
        exp_q.push_back({2'd1, 8'h44});
        exp_q.push_back({2'd2, 8'h66});
        wait_fall(0, ok, f);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_first_frame: got no busy fall, expected one");
        end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n_checks++;
            if ({stall_abort, grant_active} !== (c == 9 ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL stall_abort at ISSUE+%0d: got abort/active=%b, expected %b",
                         c - 1, {stall_abort, grant_active}, (c == 9 ? 2'b10 : 2'b01));
            end
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_next_grant: got %0d bytes pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_rst_mid;
        bit ok;
        @(negedge clk);
        src_q[3].push_back({1'b1, 8'h99});
        exp_q.push_back({2'd3, 8'h99});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) break;
        end
        repeat (2) @(negedge clk);
        rst = 1;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        n_checks++;
        if ({tx_start, grant_active, stall_abort, req_ready, tx_data, grant_id} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got start=%b active=%b abort=%b ready=%b data=%h id=%0d, expected all 0",
                     tx_start, grant_active, stall_abort, req_ready, tx_data, grant_id);
        end
        @(negedge clk);
        rst = 0;
        src_q[3].push_back({1'b1, 8'hB3});
        src_q[0].push_back({1'b1, 8'hB0});
        exp_q.push_back({2'd0, 8'hB0});
        exp_q.push_back({2'd3, 8'hB3});
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_mid_priority: got %0d bytes pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        g_valid = '0;
        g_data  = '0;
        g_last  = '0;
        test_reset;
        test_single;
        test_rr;
        test_packet;
        test_gap;
        test_stall;
        test_rst_mid;
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
